// File: rtl/iomem_arbiter.sv
// Round-robin arbiter sharing one PicoRV32-style iomem slave between two masters.
// A per-transaction timeout completes a stalled access with ERR_DATA.
//
// state | meaning
// IDLE  | no owner; arbitrate between pending requests
// BUSY0 | master 0 owns the slave port
// BUSY1 | master 1 owns the slave port
module iomem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  input  logic        tmo_clr,
  output logic        timeout_flag
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY0 = 2'd1, BUSY1 = 2'd2} state_t;

  state_t      state, state_nxt;
  logic        rr, rr_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        tmo_set;

  logic busy, sel, act_valid, done, tmo_hit;

  assign busy      = (state == BUSY0) || (state == BUSY1);
  assign sel       = (state == BUSY1);
  assign act_valid = sel ? m1_valid : m0_valid;
  assign done      = busy && s_ready;
  // s_ready on the last allowed cycle counts as a normal completion.
  assign tmo_hit   = busy && act_valid && !s_ready && (cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr           <= 1'b0;
      cnt          <= 16'd0;
      timeout_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      rr    <= rr_nxt;
      cnt   <= cnt_nxt;
      if (tmo_set)      timeout_flag <= 1'b1;
      else if (tmo_clr) timeout_flag <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr;
    cnt_nxt   = cnt;
    tmo_set   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = 16'd0;
        if (m0_valid && m1_valid) state_nxt = rr ? BUSY1 : BUSY0;
        else if (m0_valid)        state_nxt = BUSY0;
        else if (m1_valid)        state_nxt = BUSY1;
      end
      BUSY0, BUSY1: begin
        if (done) begin
          state_nxt = IDLE;
          rr_nxt    = ~sel;
          cnt_nxt   = 16'd0;
        end else if (!act_valid) begin
          // Requester withdrew: abandon without a ready pulse or rotation.
          state_nxt = IDLE;
          cnt_nxt   = 16'd0;
        end else if (tmo_hit) begin
          state_nxt = IDLE;
          rr_nxt    = ~sel;
          cnt_nxt   = 16'd0;
          tmo_set   = 1'b1;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant    = 2'b00;
    s_valid  = 1'b0;
    s_wstrb  = 4'd0;
    s_addr   = 32'd0;
    s_wdata  = 32'd0;
    m0_ready = 1'b0;
    m0_rdata = 32'd0;
    m1_ready = 1'b0;
    m1_rdata = 32'd0;
    if (busy) begin
      grant   = sel ? 2'b10 : 2'b01;
      s_valid = act_valid && !tmo_hit;
      s_wstrb = sel ? m1_wstrb : m0_wstrb;
      s_addr  = sel ? m1_addr  : m0_addr;
      s_wdata = sel ? m1_wdata : m0_wdata;
      if (sel) begin
        m1_ready = done || tmo_hit;
        m1_rdata = done ? s_rdata : (tmo_hit ? ERR_DATA : 32'd0);
      end else begin
        m0_ready = done || tmo_hit;
        m0_rdata = done ? s_rdata : (tmo_hit ? ERR_DATA : 32'd0);
      end
    end
  end

endmodule
